// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB write-through and flush/freeze control.
// Optional bubble counter on STALL_CNT when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_valid,
    input  logic [4:0]        ID_RS_ADDR,
    input  logic [4:0]        ID_RT_ADDR,
    input  logic [4:0]        ID_RD_ADDR,
    input  logic              ID_UsesRT,
    input  logic [DATA_W-1:0] ID_RS_DATA,
    input  logic [DATA_W-1:0] ID_RT_DATA,
    input  logic [DATA_W-1:0] ID_IMM,
    input  logic [CTRL_W-1:0] ID_CTRL,
    input  logic [4:0]        MEM_WB_RD,
    input  logic              MEM_WB_RegWrite,
    input  logic [DATA_W-1:0] WB_DATA,
    input  logic              EX_Flush,
    input  logic              MEM_Busy,
    output logic              ID_EX_valid,
    output logic [4:0]        ID_EX_RS,
    output logic [4:0]        ID_EX_RT,
    output logic [4:0]        ID_EX_RD,
    output logic [DATA_W-1:0] ID_EX_RS_DATA,
    output logic [DATA_W-1:0] ID_EX_RT_DATA,
    output logic [DATA_W-1:0] ID_EX_IMM,
    output logic [CTRL_W-1:0] ID_EX_CTRL,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       STALL_CNT,
`endif
    output logic              Stall
);

    localparam int MEMREAD_BIT = 7;

    logic              valid_q,   valid_d;
    logic [4:0]        rs_q,      rs_d;
    logic [4:0]        rt_q,      rt_d;
    logic [4:0]        rd_q,      rd_d;
    logic [DATA_W-1:0] rsData_q,  rsData_d;
    logic [DATA_W-1:0] rtData_q,  rtData_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;

    logic              loadUse;
    logic              rsMatch;
    logic              rtMatch;
    logic              wbRsHit;
    logic              wbRtHit;
    logic [DATA_W-1:0] rsCapture;
    logic [DATA_W-1:0] rtCapture;
    logic              luBubble;

    // A load in EX whose destination feeds the instruction in ID must be separated by one bubble.
    always_comb begin
        rsMatch = (rt_q == ID_RS_ADDR);
        rtMatch = ID_UsesRT && (rt_q == ID_RT_ADDR);
        loadUse = ID_valid && valid_q && ctrl_q[MEMREAD_BIT] &&
                  (rt_q != 5'd0) && (rsMatch || rtMatch);
    end

    assign Stall    = loadUse || MEM_Busy;
    assign luBubble = loadUse && !EX_Flush && !MEM_Busy;

    // Register-file write in WB lands the same cycle ID reads; pick up the new value here.
    always_comb begin
        wbRsHit   = MEM_WB_RegWrite && (MEM_WB_RD != 5'd0) && (MEM_WB_RD == ID_RS_ADDR);
        wbRtHit   = MEM_WB_RegWrite && (MEM_WB_RD != 5'd0) && (MEM_WB_RD == ID_RT_ADDR);
        rsCapture = wbRsHit ? WB_DATA : ID_RS_DATA;
        rtCapture = wbRtHit ? WB_DATA : ID_RT_DATA;
    end

    always_comb begin
        valid_d  = valid_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        rsData_d = rsData_q;
        rtData_d = rtData_q;
        imm_d    = imm_q;
        ctrl_d   = ctrl_q;
        if (EX_Flush || !MEM_Busy) begin
            rs_d     = ID_RS_ADDR;
            rt_d     = ID_RT_ADDR;
            rd_d     = ID_RD_ADDR;
            rsData_d = rsCapture;
            rtData_d = rtCapture;
            imm_d    = ID_IMM;
            // Bubbles clear control so forwarding never sees a stale RegWrite.
            if (EX_Flush || loadUse) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end else begin
                valid_d = ID_valid;
                ctrl_d  = ID_CTRL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            rsData_q <= '0;
            rtData_q <= '0;
            imm_q    <= '0;
            ctrl_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            rsData_q <= rsData_d;
            rtData_q <= rtData_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stallCnt_q, stallCnt_d;

    // Only load-use bubbles count; the counter sticks at all-ones.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (luBubble && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign STALL_CNT = stallCnt_q;
`else
    logic unusedLuBubble;
    assign unusedLuBubble = luBubble;
`endif

    assign ID_EX_valid   = valid_q;
    assign ID_EX_RS      = rs_q;
    assign ID_EX_RT      = rt_q;
    assign ID_EX_RD      = rd_q;
    assign ID_EX_RS_DATA = rsData_q;
    assign ID_EX_RT_DATA = rtData_q;
    assign ID_EX_IMM     = imm_q;
    assign ID_EX_CTRL    = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: hazard stall, write-through, flush/freeze priority, async reset.
// Builds with or without ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        ID_valid;
    logic [4:0]  ID_RS_ADDR, ID_RT_ADDR, ID_RD_ADDR;
    logic        ID_UsesRT;
    logic [31:0] ID_RS_DATA, ID_RT_DATA, ID_IMM;
    logic [8:0]  ID_CTRL;
    logic [4:0]  MEM_WB_RD;
    logic        MEM_WB_RegWrite;
    logic [31:0] WB_DATA;
    logic        EX_Flush, MEM_Busy;
    logic        ID_EX_valid;
    logic [4:0]  ID_EX_RS, ID_EX_RT, ID_EX_RD;
    logic [31:0] ID_EX_RS_DATA, ID_EX_RT_DATA, ID_EX_IMM;
    logic [8:0]  ID_EX_CTRL;
    logic        Stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] STALL_CNT;
`endif

    int testCount = 0;
    int failCount = 0;

    localparam logic [8:0] CTRL_LW  = 9'h1B0;
    localparam logic [8:0] CTRL_ADD = 9'h102;

    id_ex_stage #(.DATA_W(32), .CTRL_W(9)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_valid       (ID_valid),
        .ID_RS_ADDR     (ID_RS_ADDR),
        .ID_RT_ADDR     (ID_RT_ADDR),
        .ID_RD_ADDR     (ID_RD_ADDR),
        .ID_UsesRT      (ID_UsesRT),
        .ID_RS_DATA     (ID_RS_DATA),
        .ID_RT_DATA     (ID_RT_DATA),
        .ID_IMM         (ID_IMM),
        .ID_CTRL        (ID_CTRL),
        .MEM_WB_RD      (MEM_WB_RD),
        .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .WB_DATA        (WB_DATA),
        .EX_Flush       (EX_Flush),
        .MEM_Busy       (MEM_Busy),
        .ID_EX_valid    (ID_EX_valid),
        .ID_EX_RS       (ID_EX_RS),
        .ID_EX_RT       (ID_EX_RT),
        .ID_EX_RD       (ID_EX_RD),
        .ID_EX_RS_DATA  (ID_EX_RS_DATA),
        .ID_EX_RT_DATA  (ID_EX_RT_DATA),
        .ID_EX_IMM      (ID_EX_IMM),
        .ID_EX_CTRL     (ID_EX_CTRL),
`ifdef ID_EX_PERF_CNT_EN
        .STALL_CNT      (STALL_CNT),
`endif
        .Stall          (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic usesRt, input logic [31:0] rsData,
                                 input logic [31:0] rtData, input logic [31:0] imm, input logic [8:0] ctrl);
        ID_valid   = valid;
        ID_RS_ADDR = rs;
        ID_RT_ADDR = rt;
        ID_RD_ADDR = rd;
        ID_UsesRT  = usesRt;
        ID_RS_DATA = rsData;
        ID_RT_DATA = rtData;
        ID_IMM     = imm;
        ID_CTRL    = ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCount(input string tag, input logic [31:0] expected);
`ifdef ID_EX_PERF_CNT_EN
        checkOutput(tag, STALL_CNT, expected);
`else
        if (expected == 32'hFFFF_FFFF) $display("[TB] %s skipped", tag);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 9'h0);
        MEM_WB_RD = 5'd0; MEM_WB_RegWrite = 1'b0; WB_DATA = 32'h0;
        EX_Flush = 1'b0; MEM_Busy = 1'b1;
        #12;
        checkOutput("rst_valid", {31'b0, ID_EX_valid}, 32'd0);
        checkOutput("rst_ctrl", {23'b0, ID_EX_CTRL}, 32'd0);
        checkOutput("rst_stall_busy", {31'b0, Stall}, 32'd1);
        MEM_Busy = 1'b0;
        #1;
        checkOutput("rst_stall_idle", {31'b0, Stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // load-use on RS
        applyStimulus(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h200, 32'h4, CTRL_LW);
        tick();
        checkOutput("lw_valid", {31'b0, ID_EX_valid}, 32'd1);
        checkOutput("lw_rt", {27'b0, ID_EX_RT}, 32'd5);
        checkOutput("lw_ctrl", {23'b0, ID_EX_CTRL}, {23'b0, CTRL_LW});
        checkOutput("lw_rsdata", ID_EX_RS_DATA, 32'h100);
        checkOutput("lw_imm", ID_EX_IMM, 32'h4);
        applyStimulus(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 32'h11, 32'h22, 32'h0, CTRL_ADD);
        #1;
        checkOutput("lu_stall", {31'b0, Stall}, 32'd1);
        tick();
        checkOutput("lu_bubble_valid", {31'b0, ID_EX_valid}, 32'd0);
        checkOutput("lu_bubble_ctrl", {23'b0, ID_EX_CTRL}, 32'd0);
        checkOutput("lu_stall_released", {31'b0, Stall}, 32'd0);
        checkCount("lu_cnt", 32'd1);
        tick();
        checkOutput("add_valid", {31'b0, ID_EX_valid}, 32'd1);
        checkOutput("add_ctrl", {23'b0, ID_EX_CTRL}, {23'b0, CTRL_ADD});
        checkOutput("add_rs", {27'b0, ID_EX_RS}, 32'd5);
        checkOutput("add_rd", {27'b0, ID_EX_RD}, 32'd7);

        // RT matches but is not a source
        applyStimulus(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h200, 32'h4, CTRL_LW);
        tick();
        applyStimulus(1'b1, 5'd6, 5'd5, 5'd8, 1'b0, 32'h66, 32'h55, 32'h0, CTRL_ADD);
        #1;
        checkOutput("rt_unused_stall", {31'b0, Stall}, 32'd0);
        tick();
        checkOutput("rt_unused_valid", {31'b0, ID_EX_valid}, 32'd1);
        checkOutput("rt_unused_rs", {27'b0, ID_EX_RS}, 32'd6);

        // register zero never hazards nor forwards
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 32'h1, 32'h2, 32'h0, CTRL_LW);
        tick();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, CTRL_ADD);
        MEM_WB_RD = 5'd0; MEM_WB_RegWrite = 1'b1; WB_DATA = 32'h1234_5678;
        #1;
        checkOutput("r0_stall", {31'b0, Stall}, 32'd0);
        tick();
        checkOutput("r0_valid", {31'b0, ID_EX_valid}, 32'd1);
        checkOutput("r0_rsdata", ID_EX_RS_DATA, 32'h0);

        // write-through on both operands
        applyStimulus(1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 32'h1, 32'h2, 32'h0, CTRL_ADD);
        MEM_WB_RD = 5'd7; WB_DATA = 32'hDEAD_BEEF;
        tick();
        checkOutput("wt_rsdata", ID_EX_RS_DATA, 32'hDEAD_BEEF);
        checkOutput("wt_rtdata", ID_EX_RT_DATA, 32'hDEAD_BEEF);
        MEM_WB_RegWrite = 1'b0;

        // flush beats load-use
        applyStimulus(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h200, 32'h4, CTRL_LW);
        tick();
        applyStimulus(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 32'h11, 32'h22, 32'h0, CTRL_ADD);
        EX_Flush = 1'b1;
        #1;
        checkOutput("flush_lu_stall", {31'b0, Stall}, 32'd1);
        tick();
        checkOutput("flush_lu_valid", {31'b0, ID_EX_valid}, 32'd0);
        checkOutput("flush_lu_ctrl", {23'b0, ID_EX_CTRL}, 32'd0);
        checkCount("flush_lu_cnt", 32'd1);
        EX_Flush = 1'b0;

        // freeze for three edges, then write-through on release
        applyStimulus(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 32'hAAAA, 32'hBBBB, 32'h10, CTRL_ADD);
        tick();
        applyStimulus(1'b1, 5'd9, 5'd10, 5'd11, 1'b1, 32'h1, 32'h2, 32'h3, CTRL_LW);
        MEM_Busy = 1'b1;
        #1;
        checkOutput("busy_stall", {31'b0, Stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("busy_rsdata_%0d", i), ID_EX_RS_DATA, 32'hAAAA);
            checkOutput($sformatf("busy_rd_%0d", i), {27'b0, ID_EX_RD}, 32'd4);
            checkOutput($sformatf("busy_ctrl_%0d", i), {23'b0, ID_EX_CTRL}, {23'b0, CTRL_ADD});
        end
        MEM_Busy = 1'b0;
        MEM_WB_RD = 5'd9; MEM_WB_RegWrite = 1'b1; WB_DATA = 32'h55;
        tick();
        checkOutput("release_rsdata", ID_EX_RS_DATA, 32'h55);
        checkOutput("release_rd", {27'b0, ID_EX_RD}, 32'd11);
        MEM_WB_RegWrite = 1'b0;

        // flush during freeze
        applyStimulus(1'b1, 5'd12, 5'd13, 5'd14, 1'b1, 32'h7, 32'h8, 32'h9, CTRL_ADD);
        MEM_Busy = 1'b1; EX_Flush = 1'b1;
        tick();
        checkOutput("flush_busy_valid", {31'b0, ID_EX_valid}, 32'd0);
        checkOutput("flush_busy_ctrl", {23'b0, ID_EX_CTRL}, 32'd0);
        EX_Flush = 1'b0;

        // asynchronous reset mid-cycle while frozen
        MEM_Busy = 1'b0;
        tick();
        MEM_Busy = 1'b1;
        checkOutput("pre_reset_valid", {31'b0, ID_EX_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", {31'b0, ID_EX_valid}, 32'd0);
        checkOutput("async_ctrl", {23'b0, ID_EX_CTRL}, 32'd0);
        checkOutput("async_rsdata", ID_EX_RS_DATA, 32'h0);
        checkOutput("async_rd", {27'b0, ID_EX_RD}, 32'd0);
        checkOutput("async_stall", {31'b0, Stall}, 32'd1);
        checkCount("async_cnt", 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
